vga_sync_decoder: RTL

Sink-side counterpart of the VGA timing generator. Watches an incoming hsync/vsync pair clocked on the pixel clock, recovers pixel and line coordinates, and checks line length, frame length and sync pulse widths against the 640x480 timing. Declares lock after consecutive good frames. Used for the loopback self-test of the VGA path and as a front end for capture logic.

---
 rtl/vga_sync_decoder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: recovers pixel/line position and verifies 640x480 timing
//
// Purpose: watches an incoming hsync/vsync pair on the pixel clock, rebuilds
// hcount/vcount from the sync edges, checks line length, frame length and
// both pulse widths, and declares lock after LOCK_FRAMES consecutive good frames.
//
// Ports:
//   clk          pixel clock, the only clock
//   rst          synchronous reset, active-high
//   hsync_in     incoming hsync, synchronous to clk
//   vsync_in     incoming vsync, synchronous to clk
//   hcount       recovered pixel column (656 in the first cycle hsync shows asserted)
//   vcount       recovered line (490 in the first cycle vsync shows asserted)
//   video_on     locked and inside the visible area
//   frame_start  one-cycle pulse at pixel (0,0) while locked
//   locked       timing verified
//   sync_err     one-cycle pulse when lock is lost
//
// Edge events are decoded from the new input sample against the registered
// previous sample, and act on the clock edge that registers the new sample.
// So the first cycle in which the registered hsync reads asserted is the
// "H-edge cycle", and hcount already reads H_VIS+H_FP in it.
module vga_sync_decoder #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 33,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       video_on,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam int H_TOTAL  = H_VIS + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_PULSE + V_BP;
    localparam int LINE_MAX = 2 * H_TOTAL;
    localparam int FRM_MAX  = 2 * V_TOTAL;
    localparam int LW       = $clog2(LINE_MAX + 1);
    localparam int FW       = $clog2(FRM_MAX + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_next;

    logic          hs_r, vs_r;
    logic [LW-1:0] lcnt;        // clocks since last H-edge, saturating
    logic [LW-1:0] pcnt;        // asserted clocks of current hsync pulse
    logic          to_done;     // timeout already flagged for this gap
    logic          line_armed;  // an H-edge has been seen, line length is checkable
    logic          hp_valid;    // pulse counter started at a real H-edge
    logic [FW-1:0] fcnt;        // H-edges since last V-edge
    logic [FW-1:0] vp;          // H-edges while vsync asserted
    logic          vp_valid;
    logic          frame_bad;   // bad line or bad vsync width inside current frame
    logic [2:0]    gcnt;        // consecutive good frames
    logic [2:0]    gcnt_next;
    logic          err_next;
    logic          enter_search;

    logic hs_now, hs_was, vs_now, vs_was;
    logic h_edge, h_rel, v_edge, v_rel;
    logic line_len_bad, pulse_bad, timeout, bad_line;
    logic vpulse_bad, frame_good;
    logic [FW:0] fcnt_plus;

    assign hs_now = (hsync_in == H_POL);
    assign hs_was = (hs_r == H_POL);
    assign vs_now = (vsync_in == V_POL);
    assign vs_was = (vs_r == V_POL);
    assign h_edge = hs_now && !hs_was;
    assign h_rel  = !hs_now && hs_was;
    assign v_edge = vs_now && !vs_was;
    assign v_rel  = !vs_now && vs_was;

    assign line_len_bad = h_edge && line_armed && (lcnt != LW'(H_TOTAL));
    assign pulse_bad    = h_rel && hp_valid && (pcnt != LW'(H_PULSE));
    assign timeout      = !h_edge && !to_done && (lcnt == LW'(LINE_MAX));
    assign bad_line     = line_len_bad || pulse_bad || timeout;

    // An H-edge landing on the closing V-edge belongs to the closing frame.
    assign fcnt_plus  = {1'b0, fcnt} + (FW+1)'(h_edge);
    assign vpulse_bad = v_rel && vp_valid && (vp != FW'(V_PULSE));
    assign frame_good = !frame_bad && !bad_line && !vpulse_bad
                        && (fcnt_plus == (FW+1)'(V_TOTAL));

    always_comb begin
        state_next   = state;
        gcnt_next    = gcnt;
        err_next     = 1'b0;
        enter_search = 1'b0;
        case (state)
            SEARCH: begin
                if (v_edge) begin
                    gcnt_next  = 3'd0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (v_edge) begin
                    if (frame_good) begin
                        gcnt_next = gcnt + 3'd1;
                        if (gcnt + 3'd1 >= 3'(LOCK_FRAMES)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        gcnt_next = 3'd0;
                    end
                end
            end
            LOCKED: begin
                // A coincident V-edge is consumed by the loss of lock, not reused.
                if (bad_line || (v_edge && !frame_good)) begin
                    err_next     = 1'b1;
                    enter_search = 1'b1;
                    state_next   = SEARCH;
                end
            end
            default: begin
                state_next   = SEARCH;
                enter_search = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            hs_r       <= H_POL;
            vs_r       <= V_POL;
            hcount     <= '0;
            vcount     <= '0;
            lcnt       <= '0;
            pcnt       <= '0;
            to_done    <= 1'b0;
            line_armed <= 1'b0;
            hp_valid   <= 1'b0;
            fcnt       <= '0;
            vp         <= '0;
            vp_valid   <= 1'b0;
            frame_bad  <= 1'b0;
            gcnt       <= '0;
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            hs_r <= hsync_in;
            vs_r <= vsync_in;

            if (h_edge) begin
                hcount <= 10'(H_VIS + H_FP);
            end else if (hcount == 10'(H_TOTAL - 1)) begin
                hcount <= '0;
            end else begin
                hcount <= hcount + 10'd1;
            end

            if (v_edge) begin
                vcount <= 10'(V_VIS + V_FP);
            end else if (hcount == 10'(H_TOTAL - 1)) begin
                vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
            end

            if (h_edge) begin
                lcnt <= LW'(1);
            end else if (lcnt != LW'(LINE_MAX)) begin
                lcnt <= lcnt + LW'(1);
            end

            if (h_edge) begin
                to_done <= 1'b0;
            end else if (timeout) begin
                to_done <= 1'b1;
            end

            if (enter_search) begin
                line_armed <= 1'b0;
                hp_valid   <= 1'b0;
            end else if (h_edge) begin
                line_armed <= 1'b1;
                hp_valid   <= 1'b1;
            end

            if (h_edge) begin
                pcnt <= LW'(1);
            end else if (hs_now && hs_was && pcnt != LW'(LINE_MAX)) begin
                pcnt <= pcnt + LW'(1);
            end

            if (v_edge) begin
                fcnt <= '0;
            end else if (h_edge && fcnt != FW'(FRM_MAX)) begin
                fcnt <= fcnt + FW'(1);
            end

            if (v_edge) begin
                vp <= FW'(h_edge);
            end else if (h_edge && vs_now && vp != FW'(FRM_MAX)) begin
                vp <= vp + FW'(1);
            end

            if (enter_search) begin
                vp_valid <= 1'b0;
            end else if (v_edge) begin
                vp_valid <= 1'b1;
            end

            if (v_edge) begin
                frame_bad <= 1'b0;
            end else if (bad_line || vpulse_bad) begin
                frame_bad <= 1'b1;
            end

            state    <= state_next;
            gcnt     <= gcnt_next;
            sync_err <= err_next;
            locked   <= (state_next == LOCKED);
        end
    end

    assign video_on    = locked && (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
    assign frame_start = locked && (hcount == 10'd0) && (vcount == 10'd0);

endmodule
